// File: rtl/uart_receiver.sv
// uart_receiver: 8N1-style UART receive stage.
//
// Oversamples the asynchronous serial line using a sample_tick enable from the
// baud rate generator. The start bit is qualified at mid-bit. Each data bit and
// the stop bit are then sampled one full bit period apart. Each completed frame
// is loaded into a holding register.
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-low reset
//   sample_tick    one-clk enable pulse at OVERSAMPLE x baud
//   RxD            asynchronous serial input, idle high, LSB first
//   rd_ack         one-clk pulse: the bus has read receive_buffer
//   receive_buffer last received data word
//   RDA            receive data available, not yet acknowledged
//   framing_err    stop bit of the last frame was sampled low
//   overrun_err    a frame completed while RDA was still set (sticky until rd_ack)
module uart_receiver #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 RxD,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] receive_buffer,
    output logic                 RDA,
    output logic                 framing_err,
    output logic                 overrun_err
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

    localparam logic [TickW-1:0] HalfLast = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] FullLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  LastBit  = BitW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e               state;
    logic [TickW-1:0]     tick_cnt;
    logic [BitW-1:0]      bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 rx_meta;
    logic                 rx_s;

    logic tick_last;
    logic stop_done;

    // stop_done marks the cycle whose edge completes a frame. An rd_ack in the
    // same cycle must not clear the status bits that this frame sets.
    always_comb begin
        tick_last = (tick_cnt == FullLast);
        stop_done = sample_tick && (state == StStop) && tick_last;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta        <= 1'b1;
            rx_s           <= 1'b1;
            state          <= StIdle;
            tick_cnt       <= '0;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            receive_buffer <= '0;
            RDA            <= 1'b0;
            framing_err    <= 1'b0;
            overrun_err    <= 1'b0;
        end else begin
            rx_meta <= RxD;
            rx_s    <= rx_meta;

            if (rd_ack && !stop_done) begin
                RDA         <= 1'b0;
                framing_err <= 1'b0;
                overrun_err <= 1'b0;
            end

            if (sample_tick) begin
                case (state)
                    StIdle: begin
                        if (!rx_s) begin
                            tick_cnt <= '0;
                            state    <= StStart;
                        end
                    end

                    StStart: begin
                        if (tick_cnt == HalfLast) begin
                            if (!rx_s) begin
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                                state    <= StData;
                            end else begin
                                // Low pulse shorter than half a bit: treat as noise.
                                state <= StIdle;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    StData: begin
                        if (tick_last) begin
                            // LSB arrives first, so shift right and fill from the top.
                            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                            tick_cnt  <= '0;
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (bit_cnt == LastBit) begin
                                state <= StStop;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    StStop: begin
                        if (tick_last) begin
                            receive_buffer <= shift_reg;
                            RDA            <= 1'b1;
                            framing_err    <= ~rx_s;
                            // A simultaneous rd_ack consumed the old word, so no overrun.
                            overrun_err    <= rd_ack ? 1'b0 : (overrun_err | RDA);
                            tick_cnt       <= '0;
                            // A low stop bit may be a break. Wait for the line to go
                            // high so a held-low line does not start another frame.
                            state          <= rx_s ? StIdle : StBreak;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    StBreak: begin
                        if (rx_s) begin
                            state <= StIdle;
                        end
                    end

                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver. It uses directed corner-case sequences,
// a table of hand-computed frame outcomes, and randomized frames checked against
// a frame-level behavioural model.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sample_tick = 1'b0;
    logic       RxD = 1'b1;
    logic       rd_ack = 1'b0;
    logic [7:0] receive_buffer;
    logic       RDA;
    logic       framing_err;
    logic       overrun_err;

    int errors = 0;
    int checks = 0;

    int unsigned div = 4;
    int unsigned div_cnt = 0;

    logic rda_before;
    logic rda_after;

    // Frame-level reference model state.
    logic [7:0] exp_buf;
    logic       exp_rda;
    logic       exp_fe;
    logic       exp_ov;

    typedef struct {
        bit         pre_ack;
        logic [7:0] data;
        bit         stop;
        logic [7:0] e_buf;
        bit         e_rda;
        bit         e_fe;
        bit         e_ov;
    } vec_t;

    vec_t vecs[5];

    uart_receiver #(
        .DATA_BITS (8),
        .OVERSAMPLE(16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_tick   (sample_tick),
        .RxD           (RxD),
        .rd_ack        (rd_ack),
        .receive_buffer(receive_buffer),
        .RDA           (RDA),
        .framing_err   (framing_err),
        .overrun_err   (overrun_err)
    );

    always #5 clk = ~clk;

    // Baud tick generator: one sample_tick every 'div' clocks, changed 1 after the edge.
    initial begin : tick_gen
        forever begin
            @(posedge clk);
            #1;
            sample_tick = (div_cnt == 0);
            if (div_cnt + 1 >= div) div_cnt = 0;
            else div_cnt = div_cnt + 1;
        end
    end

    initial begin : watchdog
        #900us;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] b, input logic r,
                                 input logic f, input logic o);
        check({tag, ".buf"}, 32'(receive_buffer), 32'(b));
        check({tag, ".rda"}, 32'(RDA), 32'(r));
        check({tag, ".fe"}, 32'(framing_err), 32'(f));
        check({tag, ".ov"}, 32'(overrun_err), 32'(o));
    endtask

    // Consume n sample ticks, then return 2 after the edge of the last one.
    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (sample_tick) k++;
        end
        #2;
    endtask

    // Drive one frame of 16 ticks per bit. The receiver completes the frame on the
    // 153rd tick after the falling edge when div=4 (2-flop sync plus mid-bit sampling).
    // ack_at_done drives rd_ack for exactly that tick's edge.
    task automatic send_frame(input logic [7:0] data, input logic stop, input logic ack_at_done);
        int guard = 0;
        wait_ticks(1);
        RxD = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            RxD = data[i];
            wait_ticks(16);
        end
        RxD = stop;
        wait_ticks(8);
        while (!sample_tick && guard < 64) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (!sample_tick) begin
            checks++;
            errors++;
            $display("FAIL tick_wait: got no sample_tick, required one within 64 clk");
        end
        rda_before = RDA;
        rd_ack = ack_at_done;
        @(posedge clk);
        #2;
        rd_ack = 1'b0;
        rda_after = RDA;
        wait_ticks(7);
    endtask

    task automatic do_ack();
        @(posedge clk);
        #2;
        rd_ack = 1'b1;
        @(posedge clk);
        #2;
        rd_ack = 1'b0;
    endtask

    task automatic release_break(input int low_ticks);
        wait_ticks(low_ticks);
        RxD = 1'b1;
        wait_ticks(20);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        exp_buf = 8'h00;
        exp_rda = 1'b0;
        exp_fe  = 1'b0;
        exp_ov  = 1'b0;
    endtask

    task automatic model_ack();
        exp_rda = 1'b0;
        exp_fe  = 1'b0;
        exp_ov  = 1'b0;
    endtask

    // One completed frame: the new word always lands; overrun if unread data was lost.
    task automatic model_frame(input logic [7:0] data, input logic stop, input logic ack_same);
        exp_ov  = ack_same ? 1'b0 : (exp_ov | exp_rda);
        exp_rda = 1'b1;
        exp_buf = data;
        exp_fe  = ~stop;
    endtask

    initial begin : main
        logic [7:0] d;
        logic       st;
        logic       pa;
        logic       as;
        int unsigned r;

        vecs[0] = '{1'b0, 8'h11, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h22, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 8'h33, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'h44, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 8'hC3, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0};

        #1;
        check_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        do_reset();
        wait_ticks(4);

        // Basic frame with exact completion latency.
        send_frame(8'hA5, 1'b1, 1'b0);
        check("a5.rda_before_done", 32'(rda_before), 32'd0);
        check("a5.rda_after_done", 32'(rda_after), 32'd1);
        check_outputs("a5", 8'hA5, 1'b1, 1'b0, 1'b0);

        // A 5-tick low glitch must be rejected at mid start bit.
        wait_ticks(1);
        RxD = 1'b0;
        wait_ticks(5);
        RxD = 1'b1;
        wait_ticks(24);
        check_outputs("glitch", 8'hA5, 1'b1, 1'b0, 1'b0);

        @(posedge clk);
        #2;
        rd_ack = 1'b1;
        check("ack.rda_before", 32'(RDA), 32'd1);
        @(posedge clk);
        #2;
        rd_ack = 1'b0;
        check("ack.rda_after", 32'(RDA), 32'd0);

        // Framing error followed by a held-low line, then a clean frame.
        send_frame(8'h3C, 1'b0, 1'b0);
        release_break(48);
        check_outputs("break", 8'h3C, 1'b1, 1'b1, 1'b0);
        do_ack();
        check_outputs("break_ack", 8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0);
        check_outputs("after_break", 8'h81, 1'b1, 1'b0, 1'b0);

        // Overrun, then the same pair with rd_ack on the completion clock.
        do_ack();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        check_outputs("overrun", 8'hFF, 1'b1, 1'b0, 1'b1);
        do_ack();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b1);
        check_outputs("ack_same", 8'hFF, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of data bit 4. The rest of the frame stays high.
        d = 8'hF3;
        wait_ticks(1);
        RxD = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            RxD = d[i];
            wait_ticks(16);
        end
        RxD = 1'b1;
        wait_ticks(8);
        reset = 1'b0;
        #1;
        check_outputs("midreset", 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        wait_ticks(72);
        check_outputs("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        check_outputs("post_reset", 8'h5A, 1'b1, 1'b0, 1'b0);

        // Maximum tick rate: a tick on every clock.
        do_ack();
        div = 1;
        wait_ticks(4);
        send_frame(8'hFF, 1'b1, 1'b0);
        check_outputs("fast_ff", 8'hFF, 1'b1, 1'b0, 1'b0);
        send_frame(8'h00, 1'b1, 1'b0);
        check_outputs("fast_00", 8'h00, 1'b1, 1'b0, 1'b1);
        do_ack();
        send_frame(8'h4B, 1'b1, 1'b0);
        check_outputs("fast_lsb_first", 8'h4B, 1'b1, 1'b0, 1'b0);
        div = 4;
        wait_ticks(4);

        // Table of hand-computed frame outcomes.
        do_reset();
        wait_ticks(4);
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].pre_ack) do_ack();
            send_frame(vecs[i].data, vecs[i].stop, 1'b0);
            if (!vecs[i].stop) release_break(16);
            check_outputs($sformatf("vec%0d", i), vecs[i].e_buf, vecs[i].e_rda, vecs[i].e_fe,
                          vecs[i].e_ov);
        end

        // Randomized frames against the frame-level model.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 2);
            div = (r == 0) ? 1 : ((r == 1) ? 2 : 4);
            wait_ticks(3);
            d  = 8'($urandom);
            st = ($urandom_range(0, 3) != 0);
            pa = 1'($urandom_range(0, 1));
            as = (div == 4) && ($urandom_range(0, 2) == 0);
            if (pa) begin
                do_ack();
                model_ack();
            end
            send_frame(d, st, as);
            model_frame(d, st, as);
            if (!st) release_break(int'($urandom_range(1, 48)));
            check_outputs($sformatf("rand%0d", i), exp_buf, exp_rda, exp_fe, exp_ov);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receive stage; consumes the line driven by the transmitter (8N1, idle-high, start bit low, LSB first, one stop bit).
Oversamples RxD using an enable pulse from the baud rate generator, qualifies the start bit at mid-bit, and captures one byte per frame into a holding register.
Raises RDA (receive data available) and reports framing and overrun errors to the bus interface. The bus interface clears them with a read acknowledge.

Parameters:
DATA_BITS, 8, data bits per frame.
OVERSAMPLE, 16, sample_tick pulses per bit period; must be even and >= 4.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset; all flops clear while low
sample_tick  input  1  one-clk pulse from the baud rate generator at OVERSAMPLE x baud
RxD  input  1  asynchronous serial line, idle high
rd_ack  input  1  one-clk pulse; bus has read receive_buffer
receive_buffer  output  DATA_BITS  last received byte
RDA  output  1  byte available, not yet acknowledged
framing_err  output  1  last frame's stop bit sampled low
overrun_err  output  1  a byte completed while RDA was already set

Behaviour:
- Reset values: receive_buffer=0, RDA=0, framing_err=0, overrun_err=0, state=IDLE, counters=0, both synchronizer flops=1.
- RxD passes through a 2-flop synchronizer (rx_s). All decisions use rx_s and act only on cycles where sample_tick=1.
- tick_cnt counts sample_ticks within a bit. bit_cnt counts data bits captured.
- IDLE: on tick with rx_s=0, clear tick_cnt and go to START.
- START: count ticks. On the tick where tick_cnt == OVERSAMPLE/2-1 (mid start bit):
  - rx_s=0: clear tick_cnt and bit_cnt, go to DATA.
  - rx_s=1: glitch; return to IDLE with no flag change.
- DATA: on the tick where tick_cnt == OVERSAMPLE-1 (one full bit later, mid-bit):
  - Shift rx_s into the MSB of the shift register (shift right), clear tick_cnt, increment bit_cnt.
  - After bit DATA_BITS is captured, go to STOP.
- STOP: on the tick where tick_cnt == OVERSAMPLE-1, sample the stop bit. Completion:
  - receive_buffer <= shift register, RDA <= 1, framing_err <= ~rx_s. Outputs update on the clk edge after the sampling tick (latency 1 clk).
  - rx_s=1: go to IDLE.
  - rx_s=0: go to BREAK.
- BREAK: wait for a tick with rx_s=1, then go to IDLE. A held-low line never produces a second frame.
- Overrun: at completion with RDA=1 and rd_ack=0, set overrun_err=1. The buffer is still overwritten with the new byte.
- rd_ack with no completion in the same cycle: clear RDA, framing_err and overrun_err on the next edge.
- rd_ack in the same cycle as a completion:
  - Completion wins: RDA stays 1, the new byte loads, framing_err reflects the new frame.
  - overrun_err is cleared, not set; the old byte was consumed.
- overrun_err is sticky until rd_ack. framing_err is overwritten by each completion.
- sample_tick=0 holds all state; counters never advance between ticks.
- Reset asserted mid-frame: immediate return to reset values. After reset deasserts, reception resumes only from a new falling edge seen in IDLE.
- Counter widths: tick_cnt is clog2(OVERSAMPLE) bits; bit_cnt is clog2(DATA_BITS+1) bits. No wrap occurs in normal operation because all compares are exact.

Test Plan:
- sample_tick every 4 clk, send 0xA5 frame (64 clk/bit) -> RDA rises 1 clk after the stop-bit mid-sample, receive_buffer=0xA5, framing_err=0, overrun_err=0. Then rd_ack pulse -> RDA=0 next clk.
- RxD low pulse of 5 ticks in IDLE -> START aborts at mid-bit, returns to IDLE; RDA, receive_buffer and error flags unchanged.
- Send 0x3C with stop bit low, line held low 3 bit times, then high -> receive_buffer=0x3C, RDA=1, framing_err=1. No second frame; next 0x81 frame then received correctly with framing_err=0.
- Back-to-back 0x00 then 0xFF with no rd_ack -> receive_buffer=0xFF, RDA=1, overrun_err=1. Repeat with rd_ack pulsed on the exact completion clk of the second byte -> receive_buffer=0xFF, RDA=1, overrun_err=0.
- Assert reset during bit 4 of a frame -> all outputs 0 immediately. Remainder of the aborted frame's bits with line high before next start -> next 0x5A received cleanly.
- sample_tick every 1 clk (max rate), 0xFF then 0x00 -> both bytes correct; confirm 16 ticks per bit and LSB-first ordering.
